// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous-read imem,
// and holds the IF/ID register with a one-entry skid for stalls.
module fetch_stage #(
  parameter int          DBITS               = 32,
  parameter int          INST_BIT_WIDTH      = 32,
  parameter logic [31:0] INST_SIZE           = 32'd4,
  parameter logic [31:0] START_PC            = 32'h40,
  parameter int          IMEM_ADDR_BIT_WIDTH = 11,
  parameter int          REG_INDEX_BIT_WIDTH = 4,
  parameter int          OP_BIT_WIDTH        = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           redirect_valid,
  input  logic [DBITS-1:0]               redirect_pc,
  output logic [IMEM_ADDR_BIT_WIDTH-1:0] imem_addr,
  input  logic [INST_BIT_WIDTH-1:0]      imem_data,
  output logic                           inst_valid,
  output logic [INST_BIT_WIDTH-1:0]      inst_out,
  output logic [DBITS-1:0]               pc_out,
  output logic [DBITS-1:0]               pc_plus4,
  output logic [OP_BIT_WIDTH-1:0]        op1,
  output logic [OP_BIT_WIDTH-1:0]        op2,
  output logic [REG_INDEX_BIT_WIDTH-1:0] rd,
  output logic [REG_INDEX_BIT_WIDTH-1:0] rs1,
  output logic [REG_INDEX_BIT_WIDTH-1:0] rs2,
  output logic [15:0]                    imm16
);

  logic [DBITS-1:0]          fpc;
  logic [DBITS-1:0]          dpc;
  logic                      dvalid;
  logic [INST_BIT_WIDTH-1:0] skid_inst;
  logic                      skid_valid;
  logic [DBITS-1:0]          redirect_aligned;
  logic [DBITS-1:0]          fpc_next_seq;

  assign redirect_aligned = redirect_pc & ~(DBITS'(3));
  assign fpc_next_seq     = fpc + DBITS'(INST_SIZE);

  // fetch PC, in-flight tag, skid and IF/ID; priority reset > redirect > stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc        <= DBITS'(START_PC);
      dpc        <= '0;
      dvalid     <= 1'b0;
      skid_inst  <= '0;
      skid_valid <= 1'b0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      pc_out     <= '0;
    end else if (redirect_valid) begin
      fpc        <= redirect_aligned;
      dvalid     <= 1'b0;
      skid_valid <= 1'b0;
      inst_valid <= 1'b0;
    end else if (stall) begin
      if (dvalid && !skid_valid) begin
        skid_inst  <= imem_data;
        skid_valid <= 1'b1;
      end
    end else begin
      // imem has been re-reading fpc while stalled, so the sequence resumes at fpc
      if (skid_valid) begin
        inst_out   <= skid_inst;
        inst_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        inst_out   <= imem_data;
        inst_valid <= dvalid;
      end
      pc_out <= dpc;
      dpc    <= fpc;
      dvalid <= 1'b1;
      fpc    <= fpc_next_seq;
    end
  end

  assign imem_addr = fpc[IMEM_ADDR_BIT_WIDTH+1:2];
  assign pc_plus4  = pc_out + DBITS'(INST_SIZE);

  assign op1   = inst_out[31:28];
  assign op2   = inst_out[27:24];
  assign rd    = inst_out[23:20];
  assign rs1   = inst_out[19:16];
  assign rs2   = inst_out[15:12];
  assign imm16 = inst_out[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: synchronous imem model returning word*3,
// with word 0x80 holding a field-split pattern.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [10:0] imem_addr;
   logic [31:0] imem_data;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic [3:0]  op1;
   logic [3:0]  op2;
   logic [3:0]  rd;
   logic [3:0]  rs1;
   logic [3:0]  rs2;
   logic [15:0] imm16;

   int compared;
   int mismatched;

   fetch_stage dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .imem_addr(imem_addr),
      .imem_data(imem_data),
      .inst_valid(inst_valid),
      .inst_out(inst_out),
      .pc_out(pc_out),
      .pc_plus4(pc_plus4),
      .op1(op1),
      .op2(op2),
      .rd(rd),
      .rs1(rs1),
      .rs2(rs2),
      .imm16(imm16)
   );

   // free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] memWord(input logic [10:0] a);
      if (a == 11'h080) return 32'h8A31F0F0;
      return 32'(a) * 32'd3;
   endfunction

   // synchronous-read instruction memory
   always @(posedge clk) imem_data <= memWord(imem_addr);

   task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] rp);
      stall          = s;
      redirect_valid = rv;
      redirect_pc    = rp;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0);
      tick();
      tick();
      checkOutput("rst_valid", 32'(inst_valid), 32'h0);
      checkOutput("rst_pc", pc_out, 32'h0);
      checkOutput("rst_inst", inst_out, 32'h0);
      checkOutput("rst_op1", 32'(op1), 32'h0);
      checkOutput("rst_addr", 32'(imem_addr), 32'h10);

      // reset release and pipeline fill
      reset = 1'b0;
      tick();
      checkOutput("e1_valid", 32'(inst_valid), 32'h0);
      checkOutput("e1_addr", 32'(imem_addr), 32'h11);
      tick();
      checkOutput("e2_valid", 32'(inst_valid), 32'h1);
      checkOutput("e2_pc", pc_out, 32'h40);
      checkOutput("e2_pc4", pc_plus4, 32'h44);
      checkOutput("e2_inst", inst_out, 32'h30);
      checkOutput("e2_addr", 32'(imem_addr), 32'h12);
      tick();
      checkOutput("e3_pc", pc_out, 32'h44);
      checkOutput("e3_inst", inst_out, 32'h33);
      tick();
      checkOutput("e4_pc", pc_out, 32'h48);
      checkOutput("e4_inst", inst_out, 32'h36);

      // three-cycle stall while pc_out=0x48
      applyStimulus(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("stall_pc", pc_out, 32'h48);
         checkOutput("stall_inst", inst_out, 32'h36);
      end
      applyStimulus(1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("rel1_pc", pc_out, 32'h4C);
      checkOutput("rel1_inst", inst_out, 32'h39);
      tick();
      checkOutput("rel2_pc", pc_out, 32'h50);
      checkOutput("rel2_inst", inst_out, 32'h3C);
      checkOutput("rel2_valid", 32'(inst_valid), 32'h1);

      // redirect to unaligned 0x103 while running
      applyStimulus(1'b0, 1'b1, 32'h103);
      tick();
      checkOutput("rd_valid0", 32'(inst_valid), 32'h0);
      checkOutput("rd_addr", 32'(imem_addr), 32'h40);
      applyStimulus(1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("rd_valid1", 32'(inst_valid), 32'h0);
      tick();
      checkOutput("rd_valid2", 32'(inst_valid), 32'h1);
      checkOutput("rd_pc", pc_out, 32'h100);
      checkOutput("rd_inst", inst_out, 32'hC0);

      // fill the skid, then redirect together with stall
      applyStimulus(1'b1, 1'b0, 32'h0);
      tick();
      tick();
      applyStimulus(1'b1, 1'b1, 32'h200);
      tick();
      checkOutput("rs_valid0", 32'(inst_valid), 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("rs_valid1", 32'(inst_valid), 32'h0);
      tick();
      checkOutput("rs_valid2", 32'(inst_valid), 32'h1);
      checkOutput("rs_pc", pc_out, 32'h200);
      checkOutput("rs_inst", inst_out, 32'h8A31F0F0);
      checkOutput("f_op1", 32'(op1), 32'h8);
      checkOutput("f_op2", 32'(op2), 32'hA);
      checkOutput("f_rd", 32'(rd), 32'h3);
      checkOutput("f_rs1", 32'(rs1), 32'h1);
      checkOutput("f_rs2", 32'(rs2), 32'hF);
      checkOutput("f_imm16", 32'(imm16), 32'hF0F0);

      // asynchronous reset mid-stall with the skid full
      applyStimulus(1'b1, 1'b0, 32'h0);
      tick();
      #2;
      reset = 1'b1;
      #1;
      checkOutput("ar_valid", 32'(inst_valid), 32'h0);
      checkOutput("ar_pc", pc_out, 32'h0);
      checkOutput("ar_inst", inst_out, 32'h0);
      checkOutput("ar_addr", 32'(imem_addr), 32'h10);
      tick();
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("ar_e1_valid", 32'(inst_valid), 32'h0);
      tick();
      checkOutput("ar_e2_valid", 32'(inst_valid), 32'h1);
      checkOutput("ar_e2_pc", pc_out, 32'h40);
      checkOutput("ar_e2_inst", inst_out, 32'h30);

      // PC wrap from 0xFFFFFFFC to 0
      applyStimulus(1'b0, 1'b1, 32'hFFFFFFFC);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("wr_addr", 32'(imem_addr), 32'h0);
      tick();
      checkOutput("wr_pc0", pc_out, 32'hFFFFFFFC);
      checkOutput("wr_inst0", inst_out, 32'h17FD);
      checkOutput("wr_pc4", pc_plus4, 32'h0);
      tick();
      checkOutput("wr_pc1", pc_out, 32'h0);
      checkOutput("wr_inst1", inst_out, 32'h0);
      checkOutput("wr_valid", 32'(inst_valid), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
